booth_mul_seq: RTL
==================

Name: booth_mul_seq

Overview:
Iterative radix-4 Booth multiplier that retires one Booth digit per clock, generalising the combinational digit encoder into a complete multiply unit. Parametrised operand width; signed or unsigned mode selected per operation. Valid/ready handshakes on input and output; sits between operand-issue logic and the result writeback stage. Fixed, data-independent latency.

Parameters:
WIDTH, 16, operand width in bits; even, >= 4
NDIG, WIDTH/2+1, derived localparam; number of radix-4 digits and iteration cycles

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  operand pair valid
in_ready  out  1  unit can accept operands
in_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled at accept
in_a  in  WIDTH  multiplicand
in_b  in  WIDTH  multiplier (Booth-recoded)
flush  in  1  synchronous abort of any operation in flight
out_valid  out  1  product valid
out_ready  in  1  consumer accepts product
out_product  out  2*WIDTH  product; two's complement if signed, else unsigned

Behaviour:
- Reset (rst_n low, async): state IDLE; in_ready=1, out_valid=0, out_product=0, accumulator, digit counter and operand registers cleared.
- States: IDLE -> CALC -> DONE -> IDLE.
- IDLE: in_ready=1. Accept on in_valid&&in_ready at a rising edge: latch in_a, in_b, in_signed; clear accumulator; counter=0; go to CALC.
- Operand extension to WIDTH+2 bits: sign-extend when signed, zero-extend when unsigned. This makes NDIG digits exact for both modes.
- CALC: in_ready=0. Digit i uses triplet {b[2i+1], b[2i], b[2i-1]}, b[-1]=0. Encoding: 000/111 -> 0; 001/010 -> +A; 011 -> +2A; 100 -> -2A; 101/110 -> -A.
- Partial product is computed at WIDTH+3 bits, sign-extended, weighted by 4^i and added to the accumulator; negation is one's complement plus carry-in.
- Counter increments once per cycle. After the edge processing digit NDIG-1, go to DONE.
- Latency: out_valid rises exactly NDIG rising edges after the accepting edge (9 for WIDTH=16), independent of data; no zero-digit skipping.
- DONE: out_valid=1; out_product = low 2*WIDTH bits of the accumulator, held stable until out_valid&&out_ready.
- On output handshake: go to IDLE; out_valid=0 and in_ready=1 from the next cycle. No overlap of output handshake with the next input accept.
- in_valid while not IDLE: ignored; no buffering.
- flush: highest priority after reset. In any state the next state is IDLE with out_valid=0. The in-flight result is discarded and no input is accepted on that edge.
- Reset mid-operation: immediate return to reset values; the operation is lost.
- out_product is stable only while out_valid=1; its value at other times is unspecified.

Decomposition:
- Shared package booth_pkg: state enum (IDLE, CALC, DONE); digit-decode constants; helper function for extended width (WIDTH+2).
- Sub-module: reuse booth_enc unchanged as the per-cycle digit encoder, driven by the current 3-bit triplet (partial_reverse/zero/one/double drive the partial-product mux).
- Partial-product mux, accumulator and FSM stay in booth_mul_seq.

Test Plan:
- WIDTH=16, signed, a=-1 (0xFFFF), b=-1 -> out_product=0x00000001, out_valid exactly 9 edges after accept.
- Unsigned, a=0xFFFF, b=0xFFFF -> 0xFFFE0001; signed, a=0x8000, b=0x8000 -> 0x40000000; signed, a=0x8000, b=0x7FFF -> 0xC0008000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid -> out_product stable, in_ready=0 throughout; on out_ready=1 -> in_ready=1 the next cycle.
- in_valid with new operands during CALC -> ignored; the first result is unchanged, and the second operation is accepted only after return to IDLE.
- flush at CALC cycle 4 -> IDLE next cycle, out_valid never asserts; a following op with a=3, b=-5 signed -> 0xFFFFFFF1.
- rst_n low mid-CALC -> outputs immediately at reset values. Randomised sweep for WIDTH=4, 8, 16, both modes, vs reference model -> all products match.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared types and constants for the sequential radix-4 Booth multiplier.
package booth_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    // Triplet patterns that select zero or double-magnitude partial products
    localparam logic [2:0] DIG_ZERO_P = 3'b000;
    localparam logic [2:0] DIG_ZERO_N = 3'b111;
    localparam logic [2:0] DIG_POS2   = 3'b011;
    localparam logic [2:0] DIG_NEG2   = 3'b100;

    // Two extension bits make WIDTH/2+1 digits exact for signed and unsigned operands
    function automatic int ext_width(input int w);
        return w + 2;
    endfunction

endpackage

// File: rtl/booth_enc.sv
// Radix-4 Booth digit encoder: one multiplier triplet in, partial-product controls out.
module booth_enc
    import booth_pkg::*;
(
    input  logic [2:0] triplet_i,
    output logic       zero_o,
    output logic       one_o,
    output logic       double_o,
    output logic       partial_reverse_o
);

    assign zero_o            = (triplet_i == DIG_ZERO_P) || (triplet_i == DIG_ZERO_N);
    assign double_o          = (triplet_i == DIG_POS2) || (triplet_i == DIG_NEG2);
    assign one_o             = ~zero_o & ~double_o;
    assign partial_reverse_o = triplet_i[2] & ~zero_o;

endmodule

// File: rtl/booth_mul_seq.sv
// Iterative radix-4 Booth multiplier retiring one digit per clock, fixed latency of WIDTH/2+1 cycles.
// in_valid/in_ready and out_valid/out_ready: a transfer happens on a rising edge where both are high.
module booth_mul_seq
    import booth_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic               in_signed,
    input  logic [WIDTH-1:0]   in_a,
    input  logic [WIDTH-1:0]   in_b,
    input  logic               flush,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] out_product,
    output state_e             dbg_state
);

    localparam int NDIG = WIDTH / 2 + 1;
    localparam int EW   = ext_width(WIDTH);
    localparam int PW   = EW + 1;
    localparam int RW   = 2 * WIDTH;
    localparam int CW   = $clog2(NDIG + 1);
    localparam logic [CW-1:0] LAST_DIG = CW'(NDIG - 1);

    state_e          state_q, state_d;
    logic [EW-1:0]   a_q, a_d;
    logic [EW:0]     b_q, b_d;      // bit 0 carries b[2i-1] for the current digit
    logic [RW-1:0]   acc_q, acc_d;
    logic [CW-1:0]   cnt_q, cnt_d;

    logic            dig_zero, dig_one, dig_double, dig_neg;
    logic [PW-1:0]   pp_mag, pp;
    logic [RW-1:0]   pp_ext, acc_sum;
    logic [CW:0]     shamt;

    booth_enc u_enc (
        .triplet_i         (b_q[2:0]),
        .zero_o            (dig_zero),
        .one_o             (dig_one),
        .double_o          (dig_double),
        .partial_reverse_o (dig_neg)
    );

    assign pp_mag  = dig_one    ? {a_q[EW-1], a_q} :
                     dig_double ? {a_q, 1'b0}      : '0;
    assign pp      = dig_neg ? ~pp_mag : pp_mag;
    assign pp_ext  = {{(RW - PW){pp[PW-1]}}, pp};
    assign shamt   = {cnt_q, 1'b0};
    // Negation completes with a carry-in at the digit's weight
    assign acc_sum = acc_q + (pp_ext << shamt) + (RW'(dig_neg) << shamt);

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        a_d     = in_signed ? {{2{in_a[WIDTH-1]}}, in_a} : {2'b00, in_a};
                        b_d     = in_signed ? {{2{in_b[WIDTH-1]}}, in_b, 1'b0} : {2'b00, in_b, 1'b0};
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = CALC;
                    end
                end
                CALC: begin
                    acc_d = acc_sum;
                    b_d   = b_q >> 2;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_DIG) state_d = DONE;
                end
                DONE: begin
                    if (out_ready) state_d = IDLE;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_product = acc_q;
    assign dbg_state   = state_q;

endmodule
